// File: rtl/riscv_definitions.sv
// Shared types and helpers for the riscv_small memory responder.
//   mem_state_e : per-channel responder FSM state
//   mem_size_e  : data access size encoding (11 is illegal)
//   mem_req_t   : request payload captured by a channel on acceptance
package riscv_definitions;

    localparam int unsigned MEM_XLEN = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic                rd;
        logic                wr;
        logic [1:0]          size;
        logic [MEM_XLEN-1:0] addr;
        logic [MEM_XLEN-1:0] wdata;
    } mem_req_t;

    localparam int unsigned MEM_REQ_W = $bits(mem_req_t);

    // Misalignment, illegal size or conflicting read/write request.
    function automatic logic mem_data_err(input logic rd, input logic wr,
                                          input logic [1:0] size, input logic [1:0] off);
        logic err;
        err = (rd & wr) | (size == 2'b11);
        if (size == MEM_HALF && off[0])
            err = 1'b1;
        if (size == MEM_WORD && off != 2'b00)
            err = 1'b1;
        return err;
    endfunction

    // Right-justified value mask for an access size.
    function automatic logic [MEM_XLEN-1:0] mem_lane_mask(input logic [1:0] size);
        logic [MEM_XLEN-1:0] mask;
        case (size)
            MEM_BYTE: mask = 32'h0000_00FF;
            MEM_HALF: mask = 32'h0000_FFFF;
            default:  mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

    // Byte-lane enables for a store of the given size at byte offset off.
    function automatic logic [3:0] mem_byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << off;
            MEM_HALF: be = 4'b0011 << off;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/riscv_mem_channel.sv
// One responder channel: FSM, latency counter and accepted-request register.
//   clk, rst_n     : clock, synchronous active-low reset
//   clk_en         : freezes FSM, counter, request register and ready when low
//   req, req_data  : request strobe and payload
//   ready          : registered, high while the channel is in RESP
//   resp_load_c    : the coming edge moves the channel into (or again into) RESP
//   resp_data_c    : payload of the request that RESP will answer
//   cur_data       : payload of the request currently being served
module riscv_mem_channel
    import riscv_definitions::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned PW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          req,
    input  logic [PW-1:0] req_data,
    output logic          ready,
    output logic          resp_load_c,
    output logic [PW-1:0] resp_data_c,
    output logic [PW-1:0] cur_data
);

    localparam int unsigned CNT_W = 4;
    // WAIT lasts LATENCY-1 cycles; the counter counts down to 0 in the last one.
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    mem_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    // State, counter, ready and request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MEM_IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            cur_data <= '0;
        end else if (clk_en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= (state_nxt == MEM_RESP);
            if (accept)
                cur_data <= req_data;
        end
    end

    // Next-state logic; requests are accepted only in IDLE or RESP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            MEM_IDLE, MEM_RESP: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        state_nxt = MEM_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = MEM_RESP;
                    end
                end else begin
                    state_nxt = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                if (cnt == '0)
                    state_nxt = MEM_RESP;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    assign resp_load_c = clk_en && (state_nxt == MEM_RESP);
    // Entering RESP from WAIT serves the stored request, otherwise the incoming one.
    assign resp_data_c = (state == MEM_WAIT) ? cur_data : req_data;

endmodule

// File: rtl/riscv_mem_responder.sv
// Cycle-accurate instruction/data memory responder for riscv_small benches.
//   INST_DEPTH/DATA_DEPTH     : array depths in words (power of two)
//   INST_LATENCY/DATA_LATENCY : request-to-ready cycles (1..15)
//   inst_*  : read-only instruction port (word access, misalign -> inst_err)
//   data_*  : byte/half/word load-store port (errors -> data_err, no write)
//   load_*  : preload port, writes either array regardless of clk_en
module riscv_mem_responder
    import riscv_definitions::*;
#(
    parameter int unsigned INST_DEPTH   = 256,
    parameter int unsigned DATA_DEPTH   = 256,
    parameter int unsigned INST_LATENCY = 1,
    parameter int unsigned DATA_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        inst_rd_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_ready,
    output logic        inst_err,
    input  logic        data_rd_en_ma,
    input  logic        data_wr_en_ma,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr,
    input  logic [1:0]  data_rd_wr_ctrl,
    output logic [31:0] data_rd,
    output logic        data_ready,
    output logic        data_err,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [15:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IAW = $clog2(INST_DEPTH);
    localparam int unsigned DAW = $clog2(DATA_DEPTH);

    logic [31:0] inst_mem [INST_DEPTH];
    logic [31:0] data_mem [DATA_DEPTH];

    // ---------------- instruction channel ----------------
    logic           i_load_c;
    logic [31:0]    i_resp_addr_c;
    logic [31:0]    i_cur_unused;
    logic [IAW-1:0] i_idx;
    logic [31:0]    i_word;
    logic           i_err_c;

    riscv_mem_channel #(.LATENCY(INST_LATENCY), .PW(32)) u_inst_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .req         (inst_rd_en),
        .req_data    (inst_addr),
        .ready       (inst_ready),
        .resp_load_c (i_load_c),
        .resp_data_c (i_resp_addr_c),
        .cur_data    (i_cur_unused)
    );

    // Instruction word for the coming response, with same-edge preload forwarded.
    always_comb begin
        i_idx   = i_resp_addr_c[2 +: IAW];
        i_err_c = (i_resp_addr_c[1:0] != 2'b00);
        i_word  = inst_mem[i_idx];
        if (load_en && !load_sel && load_addr[IAW-1:0] == i_idx)
            i_word = load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_data <= '0;
            inst_err  <= 1'b0;
        end else if (i_load_c) begin
            inst_data <= i_err_c ? '0 : i_word;
            inst_err  <= i_err_c;
        end
    end

    // ---------------- data channel ----------------
    mem_req_t       d_req_c;
    mem_req_t       d_resp_c;
    mem_req_t       d_cur;
    logic           d_load_c;
    logic [DAW-1:0] d_idx;
    logic [31:0]    d_word;
    logic           d_err_c;
    logic [31:0]    d_rd_c;
    logic [DAW-1:0] wr_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_aligned;
    logic [31:0]    wr_merged;
    logic           wr_commit;

    assign d_req_c = '{rd:    data_rd_en_ma,
                       wr:    data_wr_en_ma,
                       size:  data_rd_wr_ctrl,
                       addr:  data_addr,
                       wdata: data_wr};

    riscv_mem_channel #(.LATENCY(DATA_LATENCY), .PW(MEM_REQ_W)) u_data_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .req         (data_rd_en_ma | data_wr_en_ma),
        .req_data    (d_req_c),
        .ready       (data_ready),
        .resp_load_c (d_load_c),
        .resp_data_c (d_resp_c),
        .cur_data    (d_cur)
    );

    // Store merge for the request being served; commits at the edge ending RESP.
    always_comb begin
        wr_idx     = d_cur.addr[2 +: DAW];
        wr_be      = mem_byte_en(d_cur.size, d_cur.addr[1:0]);
        wr_aligned = d_cur.wdata << {d_cur.addr[1:0], 3'b000};
        wr_merged  = data_mem[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b])
                wr_merged[8*b +: 8] = wr_aligned[8*b +: 8];
        end
        wr_commit = rst_n && clk_en && data_ready && d_cur.wr &&
                    !mem_data_err(d_cur.rd, d_cur.wr, d_cur.size, d_cur.addr[1:0]);
    end

    // Load value for the coming response; forwards a store or preload landing on the same edge.
    always_comb begin
        d_idx   = d_resp_c.addr[2 +: DAW];
        d_err_c = mem_data_err(d_resp_c.rd, d_resp_c.wr, d_resp_c.size, d_resp_c.addr[1:0]);
        d_word  = data_mem[d_idx];
        if (wr_commit && wr_idx == d_idx)
            d_word = wr_merged;
        if (load_en && load_sel && load_addr[DAW-1:0] == d_idx)
            d_word = load_data;
        d_rd_c = '0;
        if (d_resp_c.rd && !d_err_c)
            d_rd_c = (d_word >> {d_resp_c.addr[1:0], 3'b000}) & mem_lane_mask(d_resp_c.size);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_rd  <= '0;
            data_err <= 1'b0;
        end else if (d_load_c) begin
            data_rd  <= d_rd_c;
            data_err <= d_err_c;
        end
    end

    // Arrays are never reset; preload is written last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (wr_commit)
            data_mem[wr_idx] <= wr_merged;
        if (load_en) begin
            if (load_sel)
                data_mem[load_addr[DAW-1:0]] <= load_data;
            else
                inst_mem[load_addr[IAW-1:0]] <= load_data;
        end
    end

    // Upper address bits alias by design.
    logic unused_ok;
    assign unused_ok = ^{load_addr, i_resp_addr_c, i_cur_unused, d_resp_c, d_cur};

endmodule

// File: tb/tb_riscv_mem_responder.sv
module tb_riscv_mem_responder;

    localparam int IL = 1;
    localparam int DL = 3;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        inst_rd_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic        inst_err;
    logic        data_rd_en_ma;
    logic        data_wr_en_ma;
    logic [31:0] data_addr;
    logic [31:0] data_wr;
    logic [1:0]  data_rd_wr_ctrl;
    logic [31:0] data_rd;
    logic        data_ready;
    logic        data_err;
    logic        load_en;
    logic        load_sel;
    logic [15:0] load_addr;
    logic [31:0] load_data;

    riscv_mem_responder #(
        .INST_DEPTH(256), .DATA_DEPTH(256),
        .INST_LATENCY(IL), .DATA_LATENCY(DL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_data(inst_data),
        .inst_ready(inst_ready), .inst_err(inst_err),
        .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
        .data_addr(data_addr), .data_wr(data_wr), .data_rd_wr_ctrl(data_rd_wr_ctrl),
        .data_rd(data_rd), .data_ready(data_ready), .data_err(data_err),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t dq[$];
    exp_t iq[$];
    exp_t de;
    exp_t ie;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    localparam logic [31:0] I_LW    = 32'h0000_2083;
    localparam logic [31:0] I_ADDI1 = 32'h0640_0113;
    localparam logic [31:0] I_ADDI2 = 32'h0960_0193;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard monitor: compare every response against the oldest expectation.
    always @(negedge clk) begin
        if (data_ready) begin
            if (dq.size() == 0) begin
                check("data_unexpected_ready", 32'd1, 32'd0);
            end else begin
                de = dq.pop_front();
                check("data_cycle", 32'(cyc), 32'(de.cyc));
                check("data_rd", data_rd, de.data);
                check("data_err", 32'(data_err), 32'(de.err));
            end
        end
        if (inst_ready) begin
            if (iq.size() == 0) begin
                check("inst_unexpected_ready", 32'd1, 32'd0);
            end else begin
                ie = iq.pop_front();
                check("inst_cycle", 32'(cyc), 32'(ie.cyc));
                check("inst_data", inst_data, ie.data);
                check("inst_err", 32'(inst_err), 32'(ie.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pload(input logic sel, input logic [15:0] a, input logic [31:0] d);
        load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    // One data request, expected response pushed before the accepting edge.
    task automatic dreq(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee);
        data_rd_en_ma = rd; data_wr_en_ma = wr; data_rd_wr_ctrl = sz;
        data_addr = a; data_wr = wd;
        dq.push_back('{cyc + DL, ed, ee});
        step();
        data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0;
        data_addr = 32'hFFFF_FFFF; data_wr = 32'hFFFF_FFFF;
        repeat (DL + 1) step();
    endtask

    task automatic ireq(input logic [31:0] a, input logic [31:0] ed, input logic ee);
        inst_rd_en = 1'b1; inst_addr = a;
        iq.push_back('{cyc + IL, ed, ee});
        step();
        inst_rd_en = 1'b0;
        repeat (IL + 1) step();
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1;
        inst_rd_en = 1'b0; inst_addr = '0;
        data_rd_en_ma = 1'b0; data_wr_en_ma = 1'b0; data_addr = '0; data_wr = '0;
        data_rd_wr_ctrl = 2'b10;
        load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) step();

        check("rst_inst_ready", 32'(inst_ready), 32'd0);
        check("rst_inst_err", 32'(inst_err), 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_data_err", 32'(data_err), 32'd0);
        check("rst_data_rd", data_rd, 32'd0);

        // Preload while reset is held; arrays are not reset.
        pload(1'b1, 16'd5, 32'd5);
        pload(1'b1, 16'd2, 32'h1111_1111);
        pload(1'b0, 16'd0, I_LW);
        pload(1'b0, 16'd1, I_ADDI1);
        pload(1'b0, 16'd2, I_ADDI2);
        rst_n = 1'b1;
        step();

        // Loads and stores of every size.
        dreq(1, 0, 2'b10, 32'd20, '0, 32'd5, 0);
        dreq(0, 1, 2'b10, 32'd8, 32'hDEAD_BEEF, 32'd0, 0);
        dreq(1, 0, 2'b00, 32'd9, '0, 32'h0000_00BE, 0);
        dreq(1, 0, 2'b01, 32'd10, '0, 32'h0000_DEAD, 0);
        dreq(1, 0, 2'b00, 32'd11, '0, 32'h0000_00DE, 0);
        dreq(0, 1, 2'b00, 32'd8, 32'hAAAA_AA55, 32'd0, 0);
        dreq(0, 1, 2'b01, 32'd10, 32'h0000_1234, 32'd0, 0);
        dreq(1, 0, 2'b10, 32'd8, '0, 32'h1234_BE55, 0);
        dreq(1, 0, 2'b10, 32'h0000_0414, '0, 32'd5, 0);

        // Instruction stream: three back-to-back requests.
        inst_rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] w;
            w = (k == 0) ? I_LW : (k == 1) ? I_ADDI1 : I_ADDI2;
            inst_addr = 32'(4 * k);
            iq.push_back('{cyc + IL, w, 1'b0});
            step();
        end
        inst_rd_en = 1'b0;
        repeat (3) step();
        ireq(32'd2, 32'd0, 1);
        ireq(32'h0000_0404, I_ADDI1, 0);

        // Error cases; a bad store must leave memory unchanged.
        dreq(1, 0, 2'b01, 32'd3, '0, 32'd0, 1);
        dreq(1, 0, 2'b11, 32'd0, '0, 32'd0, 1);
        dreq(0, 1, 2'b10, 32'd9, 32'h0BAD_0BAD, 32'd0, 1);
        dreq(1, 1, 2'b10, 32'd8, 32'h0BAD_0BAD, 32'd0, 1);
        dreq(1, 0, 2'b10, 32'd8, '0, 32'h1234_BE55, 0);

        // clk_en low for two WAIT cycles delays the response by two; preload still lands.
        data_rd_en_ma = 1'b1; data_rd_wr_ctrl = 2'b10; data_addr = 32'd20;
        dq.push_back('{cyc + DL + 2, 32'd5, 1'b0});
        step();
        data_rd_en_ma = 1'b0;
        clk_en = 1'b0;
        load_en = 1'b1; load_sel = 1'b1; load_addr = 16'd7; load_data = 32'h0000_0077;
        step();
        load_en = 1'b0;
        step();
        clk_en = 1'b1;
        repeat (DL + 2) step();
        dreq(1, 0, 2'b10, 32'd28, '0, 32'h0000_0077, 0);

        // Reset during WAIT of a store drops it.
        data_wr_en_ma = 1'b1; data_rd_wr_ctrl = 2'b10; data_addr = 32'd20; data_wr = 32'hCAFE_F00D;
        step();
        data_wr_en_ma = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        dreq(1, 0, 2'b10, 32'd20, '0, 32'd5, 0);

        for (int t = 0; t < 50 && (dq.size() + iq.size()) != 0; t++) step();
        check("pending_responses", 32'(dq.size() + iq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
